// File: rtl/cpu_debug_cmd_queue_pkg.sv
// Shared types and constants for the CPU debug command queue.
package dbg_cmd_pkg;

  localparam int DBG_MIN_SYNC   = 2;
  localparam int DBG_DROP_CNT_W = 8;
  localparam int DBG_IR_W       = 2;
  localparam int DBG_DATA_W     = 38;

  typedef struct packed {
    logic [DBG_IR_W-1:0]   code;
    logic [DBG_DATA_W-1:0] data;
  } dbg_cmd_t;

  // One extra bit tells full from empty when the indices match
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cpu_debug_cmd_queue_strobe_sync.sv
// Strobe synchroniser with a one-cycle rising-edge event output.
module dbg_strobe_sync
  import dbg_cmd_pkg::*;
#(
  parameter int STAGES = DBG_MIN_SYNC
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic [STAGES-1:0] fill;
  logic              low_seen;

  // low_seen only arms once the chain holds real samples, so a strobe
  // already high at reset release must fall before it can fire again
  always_ff @(posedge clk) begin
    if (reset) begin
      chain    <= '0;
      fill     <= '0;
      low_seen <= 1'b0;
      rise     <= 1'b0;
    end else begin
      chain    <= {chain[STAGES-2:0], strobe};
      fill     <= {fill[STAGES-2:0], 1'b1};
      low_seen <= fill[STAGES-1] & ~chain[STAGES-1];
      rise     <= chain[STAGES-1] & low_seen;
    end
  end

endmodule

// File: rtl/cpu_debug_cmd_queue.sv
// CPU debug command queue: JTAG update strobes to clk domain, FIFO, pulses.
// Optional DBG_CMD_DROP_CNT_EN adds a saturating drop_count output.
module cpu_debug_cmd_queue
  import dbg_cmd_pkg::*;
#(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int ACTION_BIT  = 37,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  localparam int NUM_CMD    = 2 ** IR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IR_W-1:0]    ir_in,
  input  logic [DATA_W-1:0]  sr,
  input  logic               vs_uir,
  input  logic               vs_udr,
  input  logic               cmd_ready,
  input  logic               clr_overflow,
  output logic               cmd_valid,
  output logic [IR_W-1:0]    cmd_code,
  output logic [DATA_W-1:0]  jdo,
  output logic [NUM_CMD-1:0] take_action,
  output logic [NUM_CMD-1:0] take_no_action,
  output logic               overflow
`ifdef DBG_CMD_DROP_CNT_EN
  ,
  output logic [DBG_DROP_CNT_W-1:0] drop_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = ptr_w(FIFO_DEPTH);

  typedef struct packed {
    logic [IR_W-1:0]   code;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic          uir_evt;
  logic          udr_evt;
  logic [IR_W-1:0] ir_reg;
  cmd_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  cmd_t          head;
  logic [NUM_CMD-1:0] hot;

  dbg_strobe_sync #(.STAGES(SYNC_STAGES)) u_uir (
    .clk    (clk),
    .reset  (reset),
    .strobe (vs_uir),
    .rise   (uir_evt)
  );

  dbg_strobe_sync #(.STAGES(SYNC_STAGES)) u_udr (
    .clk    (clk),
    .reset  (reset),
    .strobe (vs_udr),
    .rise   (udr_evt)
  );

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];
  assign hot   = NUM_CMD'(1) << head.code;

  assign cmd_valid = ~empty;
  assign cmd_code  = head.code;
  assign pop       = cmd_valid & cmd_ready;
  // A pop frees the slot in the same cycle, so full+pop still accepts
  assign push_ok   = udr_evt & (~full | pop);
  assign drop      = udr_evt & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr[AW-1:0]] <= '{code: ir_reg, data: sr};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr           <= '0;
      rptr           <= '0;
      ir_reg         <= '0;
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      overflow       <= 1'b0;
    end else begin
      if (uir_evt) ir_reg <= ir_in;
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop) begin
        rptr           <= rptr + PW'(1);
        jdo            <= head.data;
        take_action    <= head.data[ACTION_BIT] ? hot : '0;
        take_no_action <= head.data[ACTION_BIT] ? '0 : hot;
      end else begin
        take_action    <= '0;
        take_no_action <= '0;
      end
      if (drop) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

`ifdef DBG_CMD_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (clr_overflow) begin
      drop_count <= drop ? DBG_DROP_CNT_W'(1) : '0;
    end else if (drop && drop_count != '1) begin
      drop_count <= drop_count + DBG_DROP_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cpu_debug_cmd_queue.sv
// Scoreboard bench for cpu_debug_cmd_queue.
module tb_cpu_debug_cmd_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_uir;
  logic        vs_udr;
  logic        cmd_ready;
  logic        clr_overflow;
  logic        cmd_valid;
  logic [1:0]  cmd_code;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        overflow;
`ifdef DBG_CMD_DROP_CNT_EN
  logic [7:0]  drop_count;
`endif

  typedef struct {
    bit          act;
    int          code;
    logic [37:0] data;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  localparam logic [37:0] ACT = 38'h20_0000_0000;

  always #5 clk = ~clk;

  cpu_debug_cmd_queue dut (
    .clk            (clk),
    .reset          (reset),
    .ir_in          (ir_in),
    .sr             (sr),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .cmd_ready      (cmd_ready),
    .clr_overflow   (clr_overflow),
    .cmd_valid      (cmd_valid),
    .cmd_code       (cmd_code),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .overflow       (overflow)
`ifdef DBG_CMD_DROP_CNT_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if ((take_action | take_no_action) != 4'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {take_action, take_no_action}, 64'h0);
      end else begin
        exp_t e;
        logic [3:0] hot;
        e = sb.pop_front();
        hot = 4'b0001 << e.code;
        chk("take_action", take_action, e.act ? hot : 4'b0);
        chk("take_no_action", take_no_action, e.act ? 4'b0 : hot);
        chk("jdo", jdo, e.data);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_uir(input logic [1:0] code);
    ir_in  = code;
    vs_uir = 1'b1;
    step(2);
    vs_uir = 1'b0;
    step(4);
  endtask

  task automatic do_udr(input logic [37:0] d);
    sr     = d;
    vs_udr = 1'b1;
    step(2);
    vs_udr = 1'b0;
    step(4);
  endtask

  task automatic expect_cmd(input bit act, input int code,
                            input logic [37:0] d);
    exp_t e;
    e.act = act;
    e.code = code;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk("drain_timeout", sb.size(), 0);
    step(3);
  endtask

  initial begin
    reset = 1'b1;
    ir_in = '0;
    sr = '0;
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    cmd_ready = 1'b0;
    clr_overflow = 1'b0;
    step(3);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_jdo", jdo, 0);
    chk("rst_pulses", {take_action, take_no_action}, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    step(5);

    // Action command, latency check
    do_uir(2'b01);
    cmd_ready = 1'b1;
    sr = ACT | 38'hA5;
    expect_cmd(1, 1, ACT | 38'hA5);
    vs_udr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("latency_low", cmd_valid, 0);
    end
    step();
    chk("latency_valid", cmd_valid, 1);
    chk("latency_code", cmd_code, 1);
    step(2);
    vs_udr = 1'b0;
    step(5);
    chk("jdo_held", jdo[7:0], 8'hA5);
    chk("queue_empty1", cmd_valid, 0);

    // No-action command on channel 3
    do_uir(2'b11);
    expect_cmd(0, 3, 38'h3C);
    do_udr(38'h3C);
    step(3);
    chk("jdo_held2", jdo[7:0], 8'h3C);

    // Overflow: five pushes into a four-deep queue
    cmd_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) expect_cmd(0, 3, 38'(k));
      do_udr(38'(k));
      if (k == 4) chk("no_ovf_at_4", overflow, 0);
    end
    chk("ovf_valid", cmd_valid, 1);
    chk("ovf_set", overflow, 1);
`ifdef DBG_CMD_DROP_CNT_EN
    chk("drop_cnt1", drop_count, 1);
`endif
    drain();
    chk("ovf_drained", cmd_valid, 0);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("ovf_clr", overflow, 0);
`ifdef DBG_CMD_DROP_CNT_EN
    chk("drop_cnt_clr", drop_count, 0);
`endif

    // Full queue, push coincident with pop
    cmd_ready = 1'b0;
    for (int k = 10; k <= 13; k++) begin
      expect_cmd(0, 3, 38'(k));
      do_udr(38'(k));
    end
    expect_cmd(0, 3, 38'd14);
    sr = 38'd14;
    vs_udr = 1'b1;
    step(3);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    step();
    vs_udr = 1'b0;
    step(4);
    chk("coincide_no_ovf", overflow, 0);
    do_udr(38'd15);
    chk("still_full_ovf", overflow, 1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    drain();

    // Long strobe: exactly one push
    do_uir(2'b10);
    expect_cmd(1, 2, ACT | 38'h55);
    sr = ACT | 38'h55;
    vs_udr = 1'b1;
    step(20);
    vs_udr = 1'b0;
    step(6);
    drain();
    step(10);
    chk("long_strobe_empty", cmd_valid, 0);

    // Reset with three entries queued, during a dequeue
    cmd_ready = 1'b0;
    do_uir(2'b00);
    for (int k = 0; k < 3; k++) begin
      expect_cmd(0, 0, 38'h21 + 38'(k));
      do_udr(38'h21 + 38'(k));
    end
    cmd_ready = 1'b1;
    step();
    reset = 1'b1;
    step();
    sb.delete();
    chk("rst_mid_valid", cmd_valid, 0);
    chk("rst_mid_pulses", {take_action, take_no_action}, 0);
    chk("rst_mid_ovf", overflow, 0);
`ifdef DBG_CMD_DROP_CNT_EN
    chk("rst_mid_drop_cnt", drop_count, 0);
`endif

    // Strobe high across reset release: no event
    vs_udr = 1'b1;
    sr = 38'h77;
    step(2);
    reset = 1'b0;
    step(10);
    chk("high_at_release", cmd_valid, 0);
    vs_udr = 1'b0;
    step(6);
    chk("fall_no_push", cmd_valid, 0);
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
